alu_operand_stage: RTL and testbench

- Parametrised successor to the ALU operand-B select mux: resolves both ALU operands, applies EX/WB forwarding, then registers them into the ID/EX pipeline boundary.
- Operand A is selected from forwarded RS1 or PC; operand B from forwarded RS2 or immediate.
- Sits between register-file read/immediate generation and the ALU in the pipelined core.
- Provides stall (hold) and flush (bubble) control. Also registers forwarded RS2 as store data.

---
 rtl/alu_operand_stage_if.sv | 44 ++++
 rtl/alu_operand_stage.sv | 101 ++++++++++
 tb/tb_alu_operand_stage.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_stage_if.sv
// Operand-stage bus: decode-side inputs, forwarding taps and registered ID/EX outputs.
// The master drives the decode and forwarding inputs; the slave (the stage) drives the registered outputs.
interface alu_operand_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  stall;
    logic                  flush;
    logic                  alu_src;
    logic                  alu_src_a;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0]       RS1_full;
    logic [XLEN-1:0]       RS2_full;
    logic [XLEN-1:0]       IMM_full;
    logic [XLEN-1:0]       pc;
    logic                  ex_wr_en;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [XLEN-1:0]       ex_result;
    logic                  wb_wr_en;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_result;
    logic                  out_valid;
    logic [XLEN-1:0]       Read1;
    logic [XLEN-1:0]       Read2;
    logic [XLEN-1:0]       store_data;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;

    modport master (
        output in_valid, stall, flush, alu_src, alu_src_a, rs1_addr, rs2_addr,
               RS1_full, RS2_full, IMM_full, pc,
               ex_wr_en, ex_rd, ex_result, wb_wr_en, wb_rd, wb_result,
        input  out_valid, Read1, Read2, store_data, fwd_a, fwd_b
    );

    modport slave (
        input  in_valid, stall, flush, alu_src, alu_src_a, rs1_addr, rs2_addr,
               RS1_full, RS2_full, IMM_full, pc,
               ex_wr_en, ex_rd, ex_result, wb_wr_en, wb_rd, wb_result,
        output out_valid, Read1, Read2, store_data, fwd_a, fwd_b
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ALU operand stage: EX/WB forwarding of RS1/RS2, operand A/B selection and
// registration into the ID/EX boundary with stall (hold) and flush (bubble).
module alu_operand_stage #(
    parameter int XLEN         = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int X0_HARDWIRED = 1
) (
    input logic                clk,
    input logic                rst_n,
    alu_operand_stage_if.slave bus
);
    logic            valid_q, valid_d;
    logic [XLEN-1:0] read1_q, read1_d;
    logic [XLEN-1:0] read2_q, read2_d;
    logic [XLEN-1:0] store_q, store_d;
    logic [1:0]      fwd_a_q, fwd_a_d;
    logic [1:0]      fwd_b_q, fwd_b_d;

    logic [XLEN-1:0] fwd_rs1, fwd_rs2;
    logic [1:0]      sel_rs1, sel_rs2;

    // A write to register 0 is discarded by the register file when x0 is hardwired,
    // so it must never be forwarded either.
    function automatic logic hit(input logic                  wr_en,
                                 input logic [REG_ADDR_W-1:0] rd,
                                 input logic [REG_ADDR_W-1:0] rs);
        return wr_en && (rd == rs) && !((X0_HARDWIRED != 0) && (rd == '0));
    endfunction

    always_comb begin
        fwd_rs1 = bus.RS1_full;
        sel_rs1 = 2'd0;
        if (hit(bus.ex_wr_en, bus.ex_rd, bus.rs1_addr)) begin
            fwd_rs1 = bus.ex_result;
            sel_rs1 = 2'd1;
        end else if (hit(bus.wb_wr_en, bus.wb_rd, bus.rs1_addr)) begin
            fwd_rs1 = bus.wb_result;
            sel_rs1 = 2'd2;
        end

        fwd_rs2 = bus.RS2_full;
        sel_rs2 = 2'd0;
        if (hit(bus.ex_wr_en, bus.ex_rd, bus.rs2_addr)) begin
            fwd_rs2 = bus.ex_result;
            sel_rs2 = 2'd1;
        end else if (hit(bus.wb_wr_en, bus.wb_rd, bus.rs2_addr)) begin
            fwd_rs2 = bus.wb_result;
            sel_rs2 = 2'd2;
        end
    end

    always_comb begin
        valid_d = valid_q;
        read1_d = read1_q;
        read2_d = read2_q;
        store_d = store_q;
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (bus.flush) begin
            valid_d = 1'b0;
            read1_d = '0;
            read2_d = '0;
            store_d = '0;
            fwd_a_d = '0;
            fwd_b_d = '0;
        end else if (!bus.stall) begin
            // Data loads regardless of in_valid; consumers qualify with out_valid.
            valid_d = bus.in_valid;
            read1_d = bus.alu_src_a ? bus.pc : fwd_rs1;
            read2_d = bus.alu_src ? bus.IMM_full : fwd_rs2;
            store_d = fwd_rs2;
            fwd_a_d = sel_rs1;
            fwd_b_d = sel_rs2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            read1_q <= '0;
            read2_q <= '0;
            store_q <= '0;
            fwd_a_q <= '0;
            fwd_b_q <= '0;
        end else begin
            valid_q <= valid_d;
            read1_q <= read1_d;
            read2_q <= read2_d;
            store_q <= store_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.Read1      = read1_q;
    assign bus.Read2      = read2_q;
    assign bus.store_data = store_q;
    assign bus.fwd_a      = fwd_a_q;
    assign bus.fwd_b      = fwd_b_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: default, x0-forwarding and 64-bit instances
// checked against hand-computed values.
module tb_alu_operand_stage;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    alu_operand_stage_if #(.XLEN(32), .REG_ADDR_W(5)) if0 ();
    alu_operand_stage_if #(.XLEN(32), .REG_ADDR_W(5)) if1 ();
    alu_operand_stage_if #(.XLEN(64), .REG_ADDR_W(5)) if2 ();

    alu_operand_stage #(.XLEN(32), .REG_ADDR_W(5), .X0_HARDWIRED(1))
        u_dut (.clk(clk), .rst_n(rst_n), .bus(if0));
    alu_operand_stage #(.XLEN(32), .REG_ADDR_W(5), .X0_HARDWIRED(0))
        u_dut_x0 (.clk(clk), .rst_n(rst_n), .bus(if1));
    alu_operand_stage #(.XLEN(64), .REG_ADDR_W(5), .X0_HARDWIRED(1))
        u_dut_w64 (.clk(clk), .rst_n(rst_n), .bus(if2));

    // The x0-forwarding instance sees exactly the same inputs as the default one.
    assign if1.in_valid  = if0.in_valid;
    assign if1.stall     = if0.stall;
    assign if1.flush     = if0.flush;
    assign if1.alu_src   = if0.alu_src;
    assign if1.alu_src_a = if0.alu_src_a;
    assign if1.rs1_addr  = if0.rs1_addr;
    assign if1.rs2_addr  = if0.rs2_addr;
    assign if1.RS1_full  = if0.RS1_full;
    assign if1.RS2_full  = if0.RS2_full;
    assign if1.IMM_full  = if0.IMM_full;
    assign if1.pc        = if0.pc;
    assign if1.ex_wr_en  = if0.ex_wr_en;
    assign if1.ex_rd     = if0.ex_rd;
    assign if1.ex_result = if0.ex_result;
    assign if1.wb_wr_en  = if0.wb_wr_en;
    assign if1.wb_rd     = if0.wb_rd;
    assign if1.wb_result = if0.wb_result;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;

        if0.in_valid  = 1'b1;  if0.stall    = 1'b0;  if0.flush     = 1'b0;
        if0.alu_src   = 1'b1;  if0.alu_src_a = 1'b1;
        if0.rs1_addr  = 5'd3;  if0.rs2_addr = 5'd6;
        if0.RS1_full  = 32'h11; if0.RS2_full = 32'h22; if0.IMM_full = 32'h33;
        if0.pc        = 32'h44;
        if0.ex_wr_en  = 1'b1;  if0.ex_rd    = 5'd3;  if0.ex_result = 32'h66;
        if0.wb_wr_en  = 1'b1;  if0.wb_rd    = 5'd6;  if0.wb_result = 32'h77;

        if2.in_valid  = 1'b0;  if2.stall    = 1'b0;  if2.flush     = 1'b0;
        if2.alu_src   = 1'b0;  if2.alu_src_a = 1'b0;
        if2.rs1_addr  = '0;    if2.rs2_addr = '0;
        if2.RS1_full  = '0;    if2.RS2_full = '0;    if2.IMM_full  = '0;
        if2.pc        = '0;
        if2.ex_wr_en  = 1'b0;  if2.ex_rd    = '0;    if2.ex_result = '0;
        if2.wb_wr_en  = 1'b0;  if2.wb_rd    = '0;    if2.wb_result = '0;

        // Load nonzero state, then assert reset mid-cycle.
        #12 rst_n = 1'b1;
        step();
        chk("preload_valid", 64'(if0.out_valid), 64'd1);
        chk("preload_read1", 64'(if0.Read1), 64'h44);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(if0.out_valid), 64'd0);
        chk("rst_read1", 64'(if0.Read1), 64'd0);
        chk("rst_read2", 64'(if0.Read2), 64'd0);
        chk("rst_store", 64'(if0.store_data), 64'd0);
        chk("rst_fwd_a", 64'(if0.fwd_a), 64'd0);
        chk("rst_fwd_b", 64'(if0.fwd_b), 64'd0);
        if0.flush = 1'b0;
        step();
        chk("rst_hold_read1", 64'(if0.Read1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after release: plain register-file operands.
        if0.alu_src = 1'b0; if0.alu_src_a = 1'b0;
        if0.RS1_full = 32'd5; if0.RS2_full = 32'd7;
        if0.ex_wr_en = 1'b0; if0.wb_wr_en = 1'b0;
        step();
        chk("basic_read1", 64'(if0.Read1), 64'd5);
        chk("basic_read2", 64'(if0.Read2), 64'd7);
        chk("basic_store", 64'(if0.store_data), 64'd7);
        chk("basic_valid", 64'(if0.out_valid), 64'd1);
        chk("basic_fwd_a", 64'(if0.fwd_a), 64'd0);
        chk("basic_fwd_b", 64'(if0.fwd_b), 64'd0);

        // Immediate and PC selection; store data still tracks RS2.
        if0.alu_src = 1'b1; if0.IMM_full = 32'hFFFF_FFF0; if0.RS2_full = 32'd3;
        if0.alu_src_a = 1'b1; if0.pc = 32'h100;
        step();
        chk("sel_read1", 64'(if0.Read1), 64'h100);
        chk("sel_read2", 64'(if0.Read2), 64'hFFFF_FFF0);
        chk("sel_store", 64'(if0.store_data), 64'd3);

        // EX beats WB on the same destination.
        if0.alu_src = 1'b0; if0.alu_src_a = 1'b0;
        if0.rs1_addr = 5'd4; if0.rs2_addr = 5'd9; if0.RS2_full = 32'd12;
        if0.ex_wr_en = 1'b1; if0.ex_rd = 5'd4; if0.ex_result = 32'hAA;
        if0.wb_wr_en = 1'b1; if0.wb_rd = 5'd4; if0.wb_result = 32'hBB;
        step();
        chk("prio_read1", 64'(if0.Read1), 64'hAA);
        chk("prio_fwd_a", 64'(if0.fwd_a), 64'd1);
        chk("prio_read2", 64'(if0.Read2), 64'd12);
        chk("prio_fwd_b", 64'(if0.fwd_b), 64'd0);
        if0.ex_wr_en = 1'b0;
        step();
        chk("wb_read1", 64'(if0.Read1), 64'hBB);
        chk("wb_fwd_a", 64'(if0.fwd_a), 64'd2);
        // Source still reported while PC drives operand A.
        if0.alu_src_a = 1'b1; if0.pc = 32'h200;
        step();
        chk("pcsel_read1", 64'(if0.Read1), 64'h200);
        chk("pcsel_fwd_a", 64'(if0.fwd_a), 64'd2);

        // RS2 forwarding from EX, reported even under immediate select.
        if0.alu_src_a = 1'b0; if0.wb_wr_en = 1'b0;
        if0.rs2_addr = 5'd9; if0.ex_wr_en = 1'b1; if0.ex_rd = 5'd9; if0.ex_result = 32'hC3;
        if0.alu_src = 1'b1; if0.IMM_full = 32'h8;
        step();
        chk("fwdb_read2", 64'(if0.Read2), 64'h8);
        chk("fwdb_store", 64'(if0.store_data), 64'hC3);
        chk("fwdb_fwd_b", 64'(if0.fwd_b), 64'd1);

        // x0 guard: hardwired instance ignores rd=0, the other forwards it.
        if0.alu_src = 1'b0; if0.rs1_addr = 5'd1; if0.RS1_full = 32'd1;
        if0.rs2_addr = 5'd0; if0.RS2_full = 32'd0;
        if0.ex_wr_en = 1'b1; if0.ex_rd = 5'd0; if0.ex_result = 32'h55;
        if0.wb_wr_en = 1'b0;
        step();
        chk("x0_read2", 64'(if0.Read2), 64'd0);
        chk("x0_fwd_b", 64'(if0.fwd_b), 64'd0);
        chk("nox0_read2", 64'(if1.Read2), 64'h55);
        chk("nox0_fwd_b", 64'(if1.fwd_b), 64'd1);
        chk("nox0_store", 64'(if1.store_data), 64'h55);

        // Stall holds for three cycles while inputs move.
        if0.ex_wr_en = 1'b0; if0.alu_src_a = 1'b0;
        if0.RS1_full = 32'd9; if0.in_valid = 1'b1;
        step();
        chk("stall_load", 64'(if0.Read1), 64'd9);
        if0.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if0.RS1_full = 32'(20 + i);
            if0.in_valid = 1'b0;
            step();
            chk("stall_read1", 64'(if0.Read1), 64'd9);
            chk("stall_valid", 64'(if0.out_valid), 64'd1);
        end
        // Flush beats stall.
        if0.flush = 1'b1;
        step();
        chk("flush_valid", 64'(if0.out_valid), 64'd0);
        chk("flush_read1", 64'(if0.Read1), 64'd0);
        chk("flush_store", 64'(if0.store_data), 64'd0);
        // Data loads with in_valid low.
        if0.flush = 1'b0; if0.stall = 1'b0; if0.in_valid = 1'b0; if0.RS1_full = 32'h3C;
        step();
        chk("novalid_valid", 64'(if0.out_valid), 64'd0);
        chk("novalid_read1", 64'(if0.Read1), 64'h3C);

        // Full 64-bit immediate passes through unmodified.
        if2.alu_src = 1'b1; if2.in_valid = 1'b1;
        if2.IMM_full = 64'h8000_0000_0000_0001;
        if2.RS2_full = 64'hDEAD_BEEF_0000_0001;
        step();
        chk("w64_read2", if2.Read2, 64'h8000_0000_0000_0001);
        chk("w64_store", if2.store_data, 64'hDEAD_BEEF_0000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
